rgb_pwm_decoder: RTL and testbench
==================================

RGB_PWM_DECODER -- requirements
Module: rgb_pwm_decoder

Interface
REQ-001 SHALL have clk, input, 1 bit: clock, all state updates on rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have pwm_r, pwm_g, pwm_b, input, 1 bit each: PWM streams with a 16-clock period and 3-bit duty (0..7 high cycles per period).
REQ-004 SHALL have err_clr, input, 1 bit: clears all err_* flags on the next rising edge.
REQ-005 SHALL have duty_r, duty_g, duty_b, output, 3 bits each: last decoded duty per channel.
REQ-006 SHALL have valid_r, valid_g, valid_b, output, 1 bit each: one-cycle pulse when the matching duty_* is updated.
REQ-007 SHALL have err_r, err_g, err_b, output, 1 bit each: sticky flag, high time of 8 or more cycles seen.

Function
REQ-008 SHALL decode the three channels independently with identical logic; simultaneous events on different channels SHALL not interact.
REQ-009 SHALL form per channel a sampled signal s (see Configuration) and its one-cycle-delayed copy s_d; rise = s & ~s_d, fall = ~s & s_d.
REQ-010 SHALL run per channel a two-state FSM, LOW and HIGH, with a 4-bit hi_cnt and a 4-bit lo_cnt.
REQ-011 LOW: on rise, go to HIGH and load hi_cnt=1; otherwise increment lo_cnt.
REQ-012 LOW: on the edge where lo_cnt would reach 16 (16 consecutive low samples), load duty=0, pulse valid, and clear lo_cnt to 0; a constant-low input SHALL pulse valid with duty 0 every 16 cycles.
REQ-013 HIGH: while s=1, increment hi_cnt, saturating at 8; on reaching 8, set err for that channel.
REQ-014 HIGH: on fall with hi_cnt in 1..7, load duty=hi_cnt, pulse valid, go to LOW, and load lo_cnt=1.
REQ-015 HIGH: on fall with hi_cnt=8, leave duty unchanged, do not pulse valid, go to LOW, and load lo_cnt=1.
REQ-016 duty_* SHALL hold its value between valid pulses.
REQ-017 valid_* SHALL be registered and high for exactly one cycle, in the cycle after the edge that detects fall (or the 16th low sample).
REQ-018 err_* SHALL stay set until err_clr or rst; if err_clr and a new err event occur on the same edge, err SHALL be set.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL set: FSMs to LOW, hi_cnt=0, lo_cnt=0, s_d=0, synchronizer flops=0, duty_*=0, valid_*=0, err_*=0.
REQ-020 Reset asserted mid-pulse SHALL discard the partial measurement; the first valid after reset SHALL come from a complete rise-to-fall pulse or from 16 low samples.

Configuration
REQ-021 With macro RGB_PWM_DEC_SYNC_EN defined, s SHALL be the output of a two-flop synchronizer on each pwm_* input, for asynchronous sources.
REQ-022 With RGB_PWM_DEC_SYNC_EN defined, valid SHALL assert 3 clock edges after the raw input falls.
REQ-023 Without RGB_PWM_DEC_SYNC_EN, s SHALL be the raw pwm_* input (same-clock source only), and valid SHALL assert 1 clock edge after the raw input falls.
REQ-024 Decoded duty values SHALL be identical in both builds.

Verification
REQ-025 Drive pwm_r high 5 cycles, low 11, for 4 periods -> valid_r pulses once per period, duty_r=5, err_r=0.
REQ-026 Hold pwm_g low 40 cycles after reset -> valid_g pulses at low samples 16 and 32, duty_g=0.
REQ-027 Drive pwm_b high 10 cycles, then low -> err_b=1 at the 8th high sample, no valid_b, duty_b unchanged; pulse err_clr -> err_b=0 next cycle.
REQ-028 Drive r=7, g=1, b=3 simultaneously with a common rise -> each valid_* asserts on its own cycle with the correct duty, and channels do not interfere.
REQ-029 Assert rst for 1 cycle at the 3rd high cycle of a duty-6 pulse -> all outputs 0; the next full period yields duty 6.
REQ-030 Run REQ-025 in both builds -> valid latency after the raw fall is 3 clocks with RGB_PWM_DEC_SYNC_EN and 1 clock without.

Source files
------------

// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder: measures high time of three 16-clock PWM streams (duty 0..7) with sticky overlength error.
// Define RGB_PWM_DEC_SYNC_EN to put a two-flop synchronizer on each pwm_* input for asynchronous sources.
module rgb_pwm_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_r,
    input  logic       pwm_g,
    input  logic       pwm_b,
    input  logic       err_clr,
    output logic [2:0] duty_r,
    output logic [2:0] duty_g,
    output logic [2:0] duty_b,
    output logic       valid_r,
    output logic       valid_g,
    output logic       valid_b,
    output logic       err_r,
    output logic       err_g,
    output logic       err_b
);
    typedef enum logic {LOW, HIGH} state_t;
    logic [2:0] pwm, s, valid_a, err_a;
    logic [2:0] duty_a [3];
    logic       s_ok;
    assign pwm = {pwm_b, pwm_g, pwm_r};
`ifdef RGB_PWM_DEC_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] fill_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= pwm;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end
    // s_ok stays low until the synchronizer holds real samples rather than reset zeros
    assign s    = sync2_q;
    assign s_ok = fill_q[1];
`else
    assign s    = pwm;
    assign s_ok = 1'b1;
`endif
    for (genvar c = 0; c < 3; c++) begin : g_ch
        state_t     state_q, state_d;
        logic [3:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
        logic [2:0] duty_q, duty_d;
        logic       s_d_q, arm_q, arm_d, valid_q, valid_d, err_q, err_d, rise, fall;
        // a rise only counts once a genuine low has been seen since reset, so a pulse cut by reset is dropped
        always_comb begin
            rise     = s[c] & ~s_d_q & arm_q;
            fall     = ~s[c] & s_d_q;
            arm_d    = arm_q | (s_ok & ~s[c]);
            state_d  = state_q;
            hi_cnt_d = hi_cnt_q;
            lo_cnt_d = lo_cnt_q;
            duty_d   = duty_q;
            valid_d  = 1'b0;
            err_d    = err_q & ~err_clr;
            if (state_q == LOW) begin
                if (rise) begin
                    state_d  = HIGH;
                    hi_cnt_d = 4'd1;
                end else if (s_ok & ~s[c]) begin
                    lo_cnt_d = lo_cnt_q + 4'd1;
                    if (lo_cnt_q == 4'd15) begin
                        duty_d  = 3'd0;
                        valid_d = 1'b1;
                    end
                end
            end else if (fall) begin
                state_d  = LOW;
                lo_cnt_d = 4'd1;
                if (hi_cnt_q != 4'd8) begin
                    duty_d  = hi_cnt_q[2:0];
                    valid_d = 1'b1;
                end
            end else if (s[c] && hi_cnt_q != 4'd8) begin
                hi_cnt_d = hi_cnt_q + 4'd1;
                if (hi_cnt_q == 4'd7) err_d = 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= LOW;
                hi_cnt_q <= '0;
                lo_cnt_q <= '0;
                duty_q   <= '0;
                s_d_q    <= 1'b0;
                arm_q    <= 1'b0;
                valid_q  <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                hi_cnt_q <= hi_cnt_d;
                lo_cnt_q <= lo_cnt_d;
                duty_q   <= duty_d;
                s_d_q    <= s[c];
                arm_q    <= arm_d;
                valid_q  <= valid_d;
                err_q    <= err_d;
            end
        end
        assign duty_a[c]  = duty_q;
        assign valid_a[c] = valid_q;
        assign err_a[c]   = err_q;
    end
    assign duty_r  = duty_a[0];
    assign duty_g  = duty_a[1];
    assign duty_b  = duty_a[2];
    assign valid_r = valid_a[0];
    assign valid_g = valid_a[1];
    assign valid_b = valid_a[2];
    assign err_r   = err_a[0];
    assign err_g   = err_a[1];
    assign err_b   = err_a[2];
endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// tb_rgb_pwm_decoder: directed checks of duty decode, low timeout, overlength error, channel independence and reset.
module tb_rgb_pwm_decoder;
    logic       clk = 1'b0, rst = 1'b1, pwm_r = 1'b0, pwm_g = 1'b0, pwm_b = 1'b0, err_clr = 1'b0;
    logic [2:0] duty_r, duty_g, duty_b;
    logic       valid_r, valid_g, valid_b, err_r, err_g, err_b;
    int         checks = 0, errors = 0;
`ifdef RGB_PWM_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    rgb_pwm_decoder dut (
        .clk(clk), .rst(rst), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .err_clr(err_clr),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .valid_r(valid_r), .valid_g(valid_g), .valid_b(valid_b),
        .err_r(err_r), .err_g(err_g), .err_b(err_b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int    n, first, second;
        int    vc [3];
        int    vi [3];
        int    vd [3];
        string nm [3];
        int    exp_i [3];
        int    exp_d [3];
        nm    = '{"r", "g", "b"};
        exp_i = '{6 + LAT, LAT, 2 + LAT};
        exp_d = '{7, 1, 3};
        // reset
        tick;
        tick;
        rst = 1'b0;
        chk("reset_outputs", {duty_r, duty_g, duty_b, valid_r, valid_g, valid_b, err_r, err_g, err_b}, 16'd0);
        // constant low: duty-0 valid every 16 low samples
        n = 0; first = 0; second = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (valid_g) begin
                n++;
                if (n == 1) first = i;
                else second = i;
            end
        end
        chk("low_g_count", n, 2);
        chk("low_g_first", first, 15 + LAT);
        chk("low_g_second", second, 31 + LAT);
        chk("low_g_duty", duty_g, 0);
        // duty 5 on red for 4 periods, with latency after raw fall
        for (int p = 0; p < 4; p++) begin
            n = 0; first = 0;
            pwm_r = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                if (i == 6) pwm_r = 1'b0;
                tick;
                if (valid_r) begin
                    n++;
                    first = i - 5;
                end
            end
            chk($sformatf("r5_count_p%0d", p), n, 1);
            chk($sformatf("r5_latency_p%0d", p), first, LAT);
            chk($sformatf("r5_duty_p%0d", p), duty_r, 5);
            chk($sformatf("r5_err_p%0d", p), err_r, 0);
        end
        // common rise, r=7 g=1 b=3
        for (int c = 0; c < 3; c++) begin
            vc[c] = 0; vi[c] = -1; vd[c] = -1;
        end
        for (int t = 0; t < 16; t++) begin
            pwm_r = (t < 7);
            pwm_g = (t < 1);
            pwm_b = (t < 3);
            tick;
            if (valid_r) begin vc[0]++; vi[0] = t; vd[0] = duty_r; end
            if (valid_g) begin vc[1]++; vi[1] = t; vd[1] = duty_g; end
            if (valid_b) begin vc[2]++; vi[2] = t; vd[2] = duty_b; end
        end
        for (int c = 0; c < 3; c++) begin
            chk({"mix_count_", nm[c]}, vc[c], 1);
            chk({"mix_time_", nm[c]}, vi[c], exp_i[c]);
            chk({"mix_duty_", nm[c]}, vd[c], exp_d[c]);
        end
        // overlength pulse on blue
        n = 0;
        pwm_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            n += int'(valid_b);
            if (i == 6 + LAT) chk("b_err_before_8", err_b, 0);
            if (i == 7 + LAT) chk("b_err_at_8", err_b, 1);
        end
        pwm_b = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick;
            n += int'(valid_b);
        end
        chk("b_long_no_valid", n, 0);
        chk("b_long_duty_held", duty_b, 3);
        chk("b_err_sticky", err_b, 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("b_err_cleared", err_b, 0);
        chk("g_err_clear", err_g, 0);
        // err_clr on the same edge as a new error event: set wins
        pwm_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            err_clr = (i == 7 + LAT);
            tick;
            if (i == 7 + LAT) chk("b_err_set_beats_clr", err_b, 1);
        end
        err_clr = 1'b0;
        pwm_b = 1'b0;
        // reset at 3rd high cycle of a duty-6 pulse on red
        pwm_r = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_outputs", {duty_r, duty_g, duty_b, valid_r, valid_g, valid_b, err_r, err_g, err_b}, 16'd0);
        n = 0;
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) pwm_r = 1'b0;
            tick;
            n += int'(valid_r);
        end
        chk("rst_partial_discarded", n, 0);
        n = 0;
        pwm_r = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 7) pwm_r = 1'b0;
            tick;
            n += int'(valid_r);
        end
        chk("rst_next_count", n, 1);
        chk("rst_next_duty", duty_r, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
